// File: rtl/bnn_host_if_if.sv
// Host-side bundle of the BNN front end: access strobes, run request and status.
// The host drives the master side; bnn_host_if takes the slave side.
interface bnn_host_if_if #(
  parameter int DATA_W  = 8,
  parameter int HOST_AW = 11
);
  logic               start;
  logic               wr_en;
  logic [HOST_AW-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               rd_en;
  logic [HOST_AW-1:0] rd_addr;
  logic               err_clr;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, wr_en, wr_addr, wr_data, rd_en, rd_addr, err_clr,
    input  rd_data, rd_valid, busy, done, err
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, rd_en, rd_addr, err_clr,
    output rd_data, rd_valid, busy, done, err
  );
endinterface

// File: rtl/bnn_host_if.sv
// Host front end of the BNN accelerator: banked activation-memory access for the host,
// start/busy/done run handshake, and hand-over of the memory ports to the controller.
module bnn_host_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int ROW_AW = 7,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bnn_host_if_if.slave            host,
  input  logic                    ctrl_idle_i,
  output logic                    ctrl_start_o,
  input  logic [ROW_AW-1:0]       ctrl_addr_rd_i,
  input  logic [ROW_AW-1:0]       ctrl_addr_wr_i,
  input  logic [LANES-1:0]        ctrl_enb_wr_i,
  output logic [ROW_AW-1:0]       act_addr_rd_o,
  output logic [ROW_AW-1:0]       act_addr_wr_o,
  output logic [LANES-1:0]        act_enb_wr_o,
  output logic [DATA_W-1:0]       act_wdata_o,
  input  logic [LANES*DATA_W-1:0] act_rdata_i
);
  localparam int LANE_W  = $clog2(LANES);
  localparam int HOST_AW = ROW_AW + LANE_W;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_e;

  state_e              state_q;
  logic                seen_low_q;
  logic                ctrl_start_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                err_d;
  logic                is_idle;
  logic                host_acc;

  logic                wr_en_q;
  logic [HOST_AW-1:0]  wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ROW_AW-1:0]   rd_row_q;
  logic [RD_LAT:0]     pipe_vld_q;
  logic [LANE_W-1:0]   pipe_lane_q [RD_LAT+1];
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   rd_lane_data;

  assign is_idle  = (state_q == IDLE);
  assign host_acc = host.wr_en | host.rd_en;

  // Completion needs ctrl_idle to have dropped at least once, so a controller that
  // is slow to react to ctrl_start cannot be mistaken for one that already finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seen_low_q   <= 1'b0;
      ctrl_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ctrl_start_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (host.start && !host_acc) begin
            state_q      <= LAUNCH;
            ctrl_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        LAUNCH: state_q <= RUN;
        RUN: begin
          if (!ctrl_idle_i) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            state_q    <= IDLE;
            seen_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (host_acc && (!is_idle || host.start)) begin
      err_d = 1'b1;
    end else if (host.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Stage 1 plus the read tracking pipe; strobes are qualified here so an access
  // rejected in the last RUN cycle cannot leak out once the mux is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_row_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_lane_q[i] <= '0;
      end
    end else begin
      wr_en_q        <= host.wr_en & is_idle;
      wr_addr_q      <= host.wr_addr;
      wr_data_q      <= host.wr_data;
      rd_row_q       <= host.rd_addr[HOST_AW-1:LANE_W];
      pipe_vld_q     <= {pipe_vld_q[RD_LAT-1:0], host.rd_en & is_idle};
      pipe_lane_q[0] <= host.rd_addr[LANE_W-1:0];
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_lane_q[i] <= pipe_lane_q[i-1];
      end
    end
  end

  assign rd_lane_data = act_rdata_i[int'(pipe_lane_q[RD_LAT])*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pipe_vld_q[RD_LAT];
      if (pipe_vld_q[RD_LAT]) begin
        rd_data_q <= rd_lane_data;
      end
    end
  end

  always_comb begin
    act_addr_rd_o = rd_row_q;
    act_addr_wr_o = wr_addr_q[HOST_AW-1:LANE_W];
    act_enb_wr_o  = '0;
    if (wr_en_q) begin
      act_enb_wr_o[wr_addr_q[LANE_W-1:0]] = 1'b1;
    end
    if (!is_idle) begin
      act_addr_rd_o = ctrl_addr_rd_i;
      act_addr_wr_o = ctrl_addr_wr_i;
      act_enb_wr_o  = ctrl_enb_wr_i;
    end
  end

  assign act_wdata_o   = wr_data_q;
  assign ctrl_start_o  = ctrl_start_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;
  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.err      = err_q;
endmodule

// File: tb/tb_bnn_host_if.sv
// Bench for bnn_host_if: banked memory model behind the DUT, a flat address-to-data
// reference with a queue of due readbacks, plus hand sequences for the run handshake.
module tb_bnn_host_if;
  localparam int LANES  = 16;
  localparam int DATA_W = 8;
  localparam int ROW_AW = 7;
  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    ctrl_idle;
  logic                    ctrl_start;
  logic [ROW_AW-1:0]       ctrl_addr_rd;
  logic [ROW_AW-1:0]       ctrl_addr_wr;
  logic [LANES-1:0]        ctrl_enb_wr;
  logic [ROW_AW-1:0]       act_addr_rd;
  logic [ROW_AW-1:0]       act_addr_wr;
  logic [LANES-1:0]        act_enb_wr;
  logic [DATA_W-1:0]       act_wdata;
  logic [LANES*DATA_W-1:0] act_rdata;

  always #5 clk = ~clk;

  bnn_host_if_if #(.DATA_W(DATA_W), .HOST_AW(11)) hb ();

  bnn_host_if #(.LANES(LANES), .DATA_W(DATA_W), .ROW_AW(ROW_AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .host(hb),
    .ctrl_idle_i(ctrl_idle), .ctrl_start_o(ctrl_start),
    .ctrl_addr_rd_i(ctrl_addr_rd), .ctrl_addr_wr_i(ctrl_addr_wr), .ctrl_enb_wr_i(ctrl_enb_wr),
    .act_addr_rd_o(act_addr_rd), .act_addr_wr_o(act_addr_wr), .act_enb_wr_o(act_enb_wr),
    .act_wdata_o(act_wdata), .act_rdata_i(act_rdata)
  );

  // Datapath memory: two-cycle read (address register, then data register).
  logic [DATA_W-1:0] mem [LANES][1<<ROW_AW];
  logic [ROW_AW-1:0] memAddrQ;
  always @(posedge clk) begin
    memAddrQ <= act_addr_rd;
    for (int k = 0; k < LANES; k++) begin
      act_rdata[k*DATA_W +: DATA_W] <= mem[k][memAddrQ];
      if (act_enb_wr[k]) mem[k][act_addr_wr] <= act_wdata;
    end
  end

  typedef struct { int due; logic [7:0] data; } rdExp_t;
  typedef struct { logic [10:0] addr; logic [7:0] data; logic [15:0] expEnb; logic [7:0] expRd; } vec_t;

  logic [7:0]  refMem [2048];
  logic [10:0] wrList [$];
  rdExp_t      expQ [$];
  vec_t        tbl [16];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Accepted accesses update the reference: a read sees every earlier write, not the one beside it.
  task automatic applyStimulus(input logic st, input logic we, input logic [10:0] wa, input logic [7:0] wd,
                               input logic re, input logic [10:0] ra, input logic clr, input logic acc);
    hb.start = st; hb.wr_en = we; hb.wr_addr = wa; hb.wr_data = wd;
    hb.rd_en = re; hb.rd_addr = ra; hb.err_clr = clr;
    if (acc) begin
      if (re) expQ.push_back('{cyc + RD_LAT + 2, refMem[ra]});
      if (we) begin
        refMem[wa] = wd;
        wrList.push_back(wa);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    hb.start = 1'b0; hb.wr_en = 1'b0; hb.rd_en = 1'b0; hb.err_clr = 1'b0;
  endtask

  task automatic waitNeg();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        checkOutput("rd_valid", 32'(hb.rd_valid), 32'd1);
        checkOutput("rd_data", 32'(hb.rd_data), 32'(expQ[0].data));
        void'(expQ.pop_front());
      end else if (hb.rd_valid) begin
        checkOutput("rd_valid_spurious", 32'(hb.rd_valid), 32'd0);
      end
    end
  end

  initial begin
    logic        we, re;
    logic [10:0] wa, ra;
    logic [7:0]  wd;

    for (int k = 0; k < 16; k++) begin
      tbl[k].addr   = 11'h230 + 11'(k);
      tbl[k].data   = 8'hA0 + 8'(k);
      tbl[k].expEnb = 16'h0001 << k;
      tbl[k].expRd  = 8'hA0 + 8'(k);
    end

    rst_n = 1'b0;
    ctrl_idle = 1'b1; ctrl_addr_rd = '0; ctrl_addr_wr = '0; ctrl_enb_wr = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle(); nextCycle();
    waitNeg();
    checkOutput("rst_busy", 32'(hb.busy), 0);
    checkOutput("rst_done", 32'(hb.done), 0);
    checkOutput("rst_err", 32'(hb.err), 0);
    checkOutput("rst_rd_valid", 32'(hb.rd_valid), 0);
    checkOutput("rst_rd_data", 32'(hb.rd_data), 0);
    checkOutput("rst_ctrl_start", 32'(ctrl_start), 0);
    checkOutput("rst_enb_wr", 32'(act_enb_wr), 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Table: writes land one cycle later on their lane, reads stream back four cycles later.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 1, tbl[k].addr, tbl[k].data, 0, 0, 0, 1);
      nextCycle();
      waitNeg();
      checkOutput("tbl_enb_wr", 32'(act_enb_wr), 32'(tbl[k].expEnb));
      checkOutput("tbl_addr_wr", 32'(act_addr_wr), 32'h23);
      checkOutput("tbl_wdata", 32'(act_wdata), 32'(tbl[k].data));
    end
    nextCycle();
    for (int i = 0; i < 19; i++) begin
      if (i < 16) applyStimulus(0, 0, 0, 0, 1, tbl[i].addr, 0, 1);
      nextCycle();
      waitNeg();
      if (i >= 3) begin
        checkOutput("tbl_rd_valid", 32'(hb.rd_valid), 1);
        checkOutput("tbl_rd_data", 32'(hb.rd_data), 32'(tbl[i-3].expRd));
      end else begin
        checkOutput("tbl_rd_latency", 32'(hb.rd_valid), 0);
      end
    end
    drain(4);

    for (int i = 0; i < 160; i++) begin
      we = 1'($urandom_range(1, 0));
      re = 1'($urandom_range(1, 0));
      wa = 11'($urandom_range(11'h7EF, 0));
      wd = 8'($urandom);
      ra = wrList[$urandom_range(wrList.size() - 1, 0)];
      if (we && re && ra == wa) re = 1'b0;
      applyStimulus(0, we, wa, wd, re, ra, 0, 1);
      nextCycle();
    end
    drain(6);

    // Start handshake, with a read accepted just before the start.
    applyStimulus(0, 0, 0, 0, 1, 11'h233, 0, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    waitNeg();
    checkOutput("hs_busy_pre", 32'(hb.busy), 0);
    for (int c = 1; c <= 33; c++) begin
      nextCycle();
      ctrl_idle = (c >= 2 && c <= 30) ? 1'b0 : 1'b1;
      waitNeg();
      checkOutput("hs_ctrl_start", 32'(ctrl_start), 32'(c == 1));
      checkOutput("hs_busy", 32'(hb.busy), 32'(c <= 31));
      checkOutput("hs_done", 32'(hb.done), 32'(c == 32));
    end

    // ctrl_idle still high after ctrl_start must not end the run.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      ctrl_idle = (c >= 7 && c <= 9) ? 1'b0 : 1'b1;
      waitNeg();
      checkOutput("lag_busy", 32'(hb.busy), 32'(c <= 10));
      checkOutput("lag_done", 32'(hb.done), 32'(c == 11));
    end

    // Host access during RUN is rejected; controller owns the ports.
    applyStimulus(0, 1, 11'h005, 8'h3C, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    ctrl_idle = 1'b0; ctrl_enb_wr = 16'h8001; ctrl_addr_wr = 7'h7F; ctrl_addr_rd = 7'h55;
    nextCycle();
    applyStimulus(0, 1, 11'h005, 8'hFF, 1, 11'h005, 0, 0);
    waitNeg();
    checkOutput("run_err_before", 32'(hb.err), 0);
    nextCycle();
    ctrl_idle = 1'b1;
    waitNeg();
    checkOutput("run_enb_wr", 32'(act_enb_wr), 32'h8001);
    checkOutput("run_addr_wr", 32'(act_addr_wr), 32'h7F);
    checkOutput("run_addr_rd", 32'(act_addr_rd), 32'h55);
    checkOutput("run_err", 32'(hb.err), 1);
    nextCycle(); nextCycle();
    waitNeg();
    checkOutput("run_busy_end", 32'(hb.busy), 0);
    ctrl_enb_wr = '0;
    applyStimulus(0, 0, 0, 0, 1, 11'h005, 0, 1);
    drain(6);
    waitNeg();
    checkOutput("err_sticky", 32'(hb.err), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle();
    waitNeg();
    checkOutput("err_clr", 32'(hb.err), 0);

    // Start with a write in IDLE: the write lands, the start is dropped, set beats clear.
    applyStimulus(1, 1, 11'h111, 8'h5A, 0, 0, 1, 1);
    nextCycle();
    waitNeg();
    checkOutput("sw_ctrl_start", 32'(ctrl_start), 0);
    checkOutput("sw_busy", 32'(hb.busy), 0);
    checkOutput("sw_err", 32'(hb.err), 1);
    checkOutput("sw_enb_wr", 32'(act_enb_wr), 32'h0002);
    checkOutput("sw_addr_wr", 32'(act_addr_wr), 32'h11);
    nextCycle();
    waitNeg();
    checkOutput("sw_busy_late", 32'(hb.busy), 0);
    applyStimulus(0, 0, 0, 0, 1, 11'h111, 0, 1);
    drain(6);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle();

    // Reset during a run with two reads in flight.
    applyStimulus(0, 0, 0, 0, 1, 11'h111, 0, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 1, 11'h005, 0, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    waitNeg();
    checkOutput("pre_rst_ctrl_start", 32'(ctrl_start), 1);
    checkOutput("pre_rst_busy", 32'(hb.busy), 1);
    checkOutput("pre_rst_err", 32'(hb.err), 1);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("arst_ctrl_start", 32'(ctrl_start), 0);
    checkOutput("arst_busy", 32'(hb.busy), 0);
    checkOutput("arst_err", 32'(hb.err), 0);
    checkOutput("arst_done", 32'(hb.done), 0);
    checkOutput("arst_rd_valid", 32'(hb.rd_valid), 0);
    checkOutput("arst_rd_data", 32'(hb.rd_data), 0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      waitNeg();
      checkOutput("rst_hold_rd_valid", 32'(hb.rd_valid), 0);
    end
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitNeg();
      checkOutput("post_rst_rd_valid", 32'(hb.rd_valid), 0);
      checkOutput("post_rst_done", 32'(hb.done), 0);
      checkOutput("post_rst_busy", 32'(hb.busy), 0);
      nextCycle();
    end
    applyStimulus(0, 1, 11'h3A7, 8'h77, 0, 0, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 11'h3A7, 0, 1);
    drain(8);

    checkOutput("readback_queue_empty", 32'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
